// File: rtl/key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : key_cmd_scheduler
// Purpose  : Queues one-cycle keyboard events in a small FIFO and releases at
//            most one command per video frame (when motion logic is idle)
//            over a valid/ready handshake.
// Options  : KEY_SCHED_COALESCE_EN - drop a key equal to the queued tail entry
// Revision : 1.0 - initial release
// ============================================================================
module key_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       key_code,
    input  logic             frame_tick,
    input  logic             busy,
    output logic             cmd_valid,
    output logic [1:0]       cmd_code,
    input  logic             cmd_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [1:0]         r_cmd_code;
    logic               r_overflow;

    logic               w_key;
    logic               w_pop;
    logic               w_full;
    logic               w_coal_drop;
    logic               w_push;
    logic               w_drop_full;
    logic               w_dispatch;

    assign w_key  = (key_code != 2'b00);
    assign w_pop  = (r_state == ISSUE) && cmd_ready;
    assign w_full = (r_level == LVL_W'(DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push      = w_key && !w_coal_drop && (!w_full || w_pop);
    assign w_drop_full = w_key && !w_coal_drop && w_full && !w_pop;

`ifdef KEY_SCHED_COALESCE_EN
    logic [1:0] r_tail_code;
    logic       r_tail_valid;

    // With a single entry in ISSUE the tail is the presented command, which
    // must never absorb a repeat key.
    assign w_coal_drop = w_key && r_tail_valid && (key_code == r_tail_code) &&
                         !((r_state == ISSUE) && (r_level == LVL_W'(1)));

    // Track the most recently queued code; forget it once the FIFO empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail_valid <= 1'b0;
            r_tail_code  <= 2'b00;
        end else if (w_level_nxt == '0) begin
            r_tail_valid <= 1'b0;
        end else if (w_push) begin
            r_tail_valid <= 1'b1;
            r_tail_code  <= key_code;
        end
    end
`else
    assign w_coal_drop = 1'b0;
`endif

    // Occupancy after this cycle's push and pop.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level    <= w_level_nxt;
            r_overflow <= w_drop_full;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; IDLE arms on the push edge to meet one-cycle latency.
    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_level_nxt != '0) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (frame_tick && !busy) begin
                    w_dispatch  = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_pop) begin
                    w_state_nxt = (w_level_nxt != '0) ? ARMED : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Presented command: loaded from the head on dispatch, zeroed on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_code <= 2'b00;
        end else if (w_dispatch) begin
            r_cmd_code <= r_mem[r_rd_ptr];
        end else if (w_pop) begin
            r_cmd_code <= 2'b00;
        end
    end

    assign cmd_valid  = (r_state == ISSUE);
    assign cmd_code   = r_cmd_code;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_cmd_scheduler
// Purpose  : Self-checking bench for key_cmd_scheduler using a queue-based
//            reference model plus directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic             clk;
    logic             rst;
    logic [1:0]       key_code;
    logic             frame_tick;
    logic             busy;
    logic             cmd_valid;
    logic [1:0]       cmd_code;
    logic             cmd_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    int checks;
    int errors;

    key_cmd_scheduler #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .frame_tick (frame_tick),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {valid, code, level, overflow}.
    logic [6:0] act;
    assign act = {cmd_valid, cmd_code, fifo_level, overflow};

    // Reference model: queue of stored codes, plus the presented command.
    logic [1:0] mq [$];
    bit         m_have;
    logic [1:0] m_cur;
    bit         m_ovf;

    function automatic logic [6:0] exp_vec();
        return {m_have, (m_have ? m_cur : 2'b00), 3'(mq.size()), m_ovf};
    endfunction

    task automatic model_step(input logic r, input logic [1:0] k,
                              input logic ft, input logic b, input logic rdy);
        int n;
        bit pop;
        bit arm;
        bit coal;
        if (r) begin
            mq.delete();
            m_have = 0;
            m_cur  = 2'b00;
            m_ovf  = 0;
        end else begin
            n    = mq.size();
            pop  = m_have && rdy;
            arm  = !m_have && (n > 0) && ft && !b;
            coal = 0;
            m_ovf = 0;
`ifdef KEY_SCHED_COALESCE_EN
            if (k != 2'b00 && n > 0 && k == mq[n-1] && !(m_have && n == 1)) coal = 1;
`endif
            if (pop) begin
                void'(mq.pop_front());
                m_have = 0;
                m_cur  = 2'b00;
            end
            if (k != 2'b00 && !coal) begin
                if (n == DEPTH && !pop) m_ovf = 1;
                else mq.push_back(k);
            end
            if (arm) begin
                m_have = 1;
                m_cur  = mq[0];
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input logic r, input logic [1:0] k,
                       input logic ft, input logic b, input logic rdy);
        rst = r; key_code = k; frame_tick = ft; busy = b; cmd_ready = rdy;
        @(posedge clk);
        model_step(r, k, ft, b, rdy);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        checks++;
        if (act !== 7'd0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", act, 7'd0);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 2'b00, (i % 5) == 0, 0, 1);
            checks++;
            if (act !== 7'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %b expected %b", i, act, 7'd0);
            end
        end
    endtask

    task automatic test_min_latency();
        logic [6:0] e [3];
        e[0] = {1'b0, 2'b00, 3'd1, 1'b0};
        e[1] = {1'b1, 2'b11, 3'd1, 1'b0};
        e[2] = {1'b0, 2'b00, 3'd0, 1'b0};
        cyc(1, 2'b00, 0, 0, 1);
        cyc(0, 2'b11, 0, 0, 1);
        checks++;
        if (act !== e[0]) begin errors++; $display("FAIL minlat_c1: got %b expected %b", act, e[0]); end
        cyc(0, 2'b00, 1, 0, 1);
        checks++;
        if (act !== e[1]) begin errors++; $display("FAIL minlat_c2: got %b expected %b", act, e[1]); end
        cyc(0, 2'b00, 0, 0, 1);
        checks++;
        if (act !== e[2]) begin errors++; $display("FAIL minlat_c3: got %b expected %b", act, e[2]); end
    endtask

    task automatic test_order_rate();
        logic [1:0] got [$];
        logic [1:0] keys [3];
        bit prev_tick;
        keys[0] = 2'b01; keys[1] = 2'b10; keys[2] = 2'b11;
        cyc(1, 2'b00, 0, 0, 1);
        prev_tick = 0;
        for (int i = 0; i < 45; i++) begin
            prev_tick = ((i % 10) == 9);
            cyc(0, (i < 3) ? keys[i] : 2'b00, prev_tick, 0, 1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL order_cycle%0d: got %b expected %b", i, act, exp_vec());
            end
            if (cmd_valid) begin
                got.push_back(cmd_code);
                checks++;
                if (!prev_tick) begin
                    errors++;
                    $display("FAIL order_rate%0d: got valid=1 expected valid only after tick", i);
                end
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL order_count: got %0d expected 3", got.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (got[j] !== keys[j]) begin
                    errors++;
                    $display("FAIL order_cmd%0d: got %b expected %b", j, got[j], keys[j]);
                end
            end
        end
    endtask

    task automatic test_busy_backpressure();
        logic [6:0] e_hold;
        e_hold = {1'b1, 2'b01, 3'd1, 1'b0};
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b01, 0, 1, 0);
        cyc(0, 2'b00, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b00, 0, i[0], 0);
            checks++;
            if (cmd_valid !== 1'b0 || act !== exp_vec()) begin
                errors++;
                $display("FAIL busy_gate%0d: got %b expected %b", i, act, exp_vec());
            end
        end
        cyc(0, 2'b00, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (act !== e_hold || act !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got %b expected %b", i, act, e_hold);
            end
            cyc(0, 2'b00, i[0], i[1], 0);
        end
        cyc(0, 2'b00, 0, 1, 1);
        checks++;
        if (act !== 7'd0) begin
            errors++;
            $display("FAIL backpressure_pop: got %b expected %b", act, 7'd0);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] keys [5];
        logic [1:0] got [$];
        logic [6:0] e_ovf;
        keys[0] = 2'b01; keys[1] = 2'b10; keys[2] = 2'b01; keys[3] = 2'b10; keys[4] = 2'b11;
        e_ovf = {1'b0, 2'b00, 3'd4, 1'b1};
        cyc(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, keys[i], 0, 0, 0);
        checks++;
        if (act !== e_ovf) begin errors++; $display("FAIL overflow_pulse: got %b expected %b", act, e_ovf); end
        cyc(0, 2'b00, 0, 0, 0);
        checks++;
        if (overflow !== 1'b0 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL overflow_single: got ovf=%b lvl=%0d expected ovf=0 lvl=4", overflow, fifo_level);
        end
        for (int i = 0; i < 40; i++) begin
            cyc(0, 2'b00, (i % 4) == 0, 0, 1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL drain_cycle%0d: got %b expected %b", i, act, exp_vec());
            end
            if (cmd_valid) got.push_back(cmd_code);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL drain_count: got %0d expected 4", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got[j] !== keys[j]) begin
                    errors++;
                    $display("FAIL drain_cmd%0d: got %b expected %b", j, got[j], keys[j]);
                end
            end
        end
    endtask

    task automatic test_full_pop_reset();
        logic [6:0] e [4];
        e[0] = {1'b1, 2'b01, 3'd4, 1'b0};
        e[1] = {1'b0, 2'b00, 3'd4, 1'b0};
        e[2] = {1'b1, 2'b10, 3'd4, 1'b0};
        e[3] = 7'd0;
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0);
        cyc(0, 2'b10, 0, 0, 0);
        cyc(0, 2'b11, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0);
        cyc(0, 2'b00, 1, 0, 0);
        checks++;
        if (act !== e[0]) begin errors++; $display("FAIL full_issue: got %b expected %b", act, e[0]); end
        cyc(0, 2'b10, 0, 0, 1);
        checks++;
        if (act !== e[1]) begin errors++; $display("FAIL full_push_pop: got %b expected %b", act, e[1]); end
        cyc(0, 2'b00, 1, 0, 0);
        checks++;
        if (act !== e[2]) begin errors++; $display("FAIL full_reissue: got %b expected %b", act, e[2]); end
        cyc(1, 2'b00, 0, 0, 1);
        checks++;
        if (act !== e[3]) begin errors++; $display("FAIL reset_mid_issue: got %b expected %b", act, e[3]); end
    endtask

    task automatic test_coalesce();
        logic [LVL_W-1:0] e_lvl;
`ifdef KEY_SCHED_COALESCE_EN
        e_lvl = 3'd1;
`else
        e_lvl = 3'd2;
`endif
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b10, 0, 0, 0);
        cyc(0, 2'b10, 0, 0, 0);
        checks++;
        if (fifo_level !== e_lvl || overflow !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_level: got lvl=%0d ovf=%b expected lvl=%0d ovf=0", fifo_level, overflow, e_lvl);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic [1:0] k;
        cyc(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 299) == 0);
            k = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(r, k, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; key_code = 2'b00; frame_tick = 1'b0; busy = 1'b0; cmd_ready = 1'b0;
        m_have = 0; m_cur = 2'b00; m_ovf = 0;
        test_reset();
        test_min_latency();
        test_order_rate();
        test_busy_backpressure();
        test_overflow();
        test_full_pop_reset();
        test_coalesce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_cmd_scheduler.md
Name: key_cmd_scheduler

Overview:
- Sits between the `keyboard` block's 2-bit `key_code` event output and the player/character motion logic.
- Buffers one-cycle key events in a small FIFO.
- Releases at most one command per video frame, and only when the motion logic is not busy.
- Delivers each command over a valid/ready handshake, so no key press is lost between frames.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LVL_W, 3, width of `fifo_level`; must hold 0..DEPTH, i.e. log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- key_code  in  2  key event: 00 none, 01 left, 10 right, 11 up/jump. Non-zero is a single-cycle pulse.
- frame_tick  in  1  one-cycle pulse per frame, e.g. from the vsync edge.
- busy  in  1  motion logic busy (jump in progress); blocks dispatch.
- cmd_valid  out  1  a command is presented.
- cmd_code  out  2  the presented command; same encoding as `key_code`.
- cmd_ready  in  1  consumer accepts `cmd_code` this cycle.
- fifo_level  out  LVL_W  number of stored entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a key event is dropped because the FIFO is full.

Behaviour:
- Reset (rst=1 at a clk edge) gives: FIFO empty, `fifo_level`=0, `cmd_valid`=0, `cmd_code`=00, `overflow`=0, state=IDLE.
- Reset mid-handshake discards the pending command and all queued entries.
- Push:
  - Occurs when `key_code`!=00.
  - The entry is written at the clock edge closing that cycle.
  - `fifo_level` increments on the next cycle.
  - `key_code`=00 is never stored.
- Pop:
  - Occurs only on handshake: `cmd_valid`&&`cmd_ready` at a clock edge.
  - The FIFO is first-in first-out.
- Full:
  - A push while `fifo_level`==DEPTH with no pop in the same cycle is dropped.
  - `overflow`=1 for the next cycle; `fifo_level` is unchanged.
- Simultaneous push and pop:
  - Both take effect and `fifo_level` is unchanged.
  - When full, the push is accepted because the pop frees a slot, and `overflow` stays 0.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states:
  - IDLE: FIFO empty, `cmd_valid`=0. Goes to ARMED when `fifo_level`>0.
  - ARMED: waits for `frame_tick`=1 && `busy`=0 in the same cycle.
    - On that cycle, `cmd_code` is loaded from the FIFO head and `cmd_valid` is asserted in the following cycle → ISSUE.
    - A `frame_tick` seen while `busy`=1 is ignored and not remembered; the block waits for a later tick.
  - ISSUE:
    - `cmd_valid`=1 and `cmd_code` are held stable until `cmd_ready`=1.
    - `busy` and `frame_tick` are ignored in this state.
    - On handshake, the entry is popped and `cmd_valid`=0 on the next cycle.
    - Next state is ARMED if entries remain after the pop, otherwise IDLE.
- Rate:
  - At most one command per `frame_tick`.
  - A `frame_tick` arriving during ISSUE does not arm a second dispatch.
- Minimum latency:
  - Key pulse at cycle 0; state is ARMED in cycle 1.
  - With `frame_tick`=1 and `busy`=0 in cycle 1, `cmd_valid`=1 in cycle 2.
  - With `cmd_ready` already high in cycle 2, the handshake completes at the end of cycle 2.
- `cmd_code` returns to 00 whenever `cmd_valid`=0.

Optional Feature:
- Macro: KEY_SCHED_COALESCE_EN.
- When defined:
  - A push whose code equals the most recently written FIFO entry (the tail) is dropped silently while that entry is still queued.
  - Such a drop does not assert `overflow` and leaves `fifo_level` unchanged.
  - Coalescing never compares against an entry already presented in ISSUE.
  - The tail-compare register is cleared when the FIFO becomes empty.
- When undefined: every non-zero key is queued, subject only to the full rule.

Test Plan:
- Reset/idle: rst held 2 cycles, then `key_code`=00 for 20 cycles → `cmd_valid`=0, `fifo_level`=0, `overflow`=0 throughout.
- Minimum latency: key 11 at cycle 0, `frame_tick` at cycle 1, `busy`=0, `cmd_ready`=1 → `cmd_valid`=1 with `cmd_code`=11 in cycle 2 only, and `fifo_level` back to 0 by cycle 3.
- Order and rate: keys 01, 10, 11 on consecutive cycles, `frame_tick` every 10 cycles, `cmd_ready`=1 → three commands 01, 10, 11, one per tick, each after its tick.
- Busy gating and backpressure:
  - One key queued; `frame_tick` while `busy`=1 → no `cmd_valid`.
  - Next tick with `busy`=0 and `cmd_ready`=0 for 5 cycles → `cmd_valid` and `cmd_code` stable for 5 cycles, pop only on `cmd_ready`.
- Overflow (DEPTH=4, no ticks): 5 keys 01, 10, 01, 10, 11 → `fifo_level`=4, one `overflow` pulse on the 5th key; later drain yields 01, 10, 01, 10.
- Full plus simultaneous pop, and reset mid-op:
  - FIFO full in ISSUE; new key in the handshake cycle → `overflow`=0, `fifo_level` stays 4.
  - Then rst=1 while in ISSUE → next cycle `cmd_valid`=0, `fifo_level`=0.
  - With KEY_SCHED_COALESCE_EN defined: keys 10, 10 → `fifo_level`=1.
